// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - framed LSB-first serial-to-parallel loader with one-cycle load pulse (optional parity: SERIAL_WORD_LOADER_PARITY_EN)
module serial_word_loader #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] d,
  output logic         en,
  output logic         busy,
  output logic         frame_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [N-1:0]   d_q, d_d;
  logic           en_q, en_d;
  logic           err_q, err_d;

  // Partial word with the current bit written at position cnt_q.
  logic [N-1:0]   sh_ins;
  // A fresh frame: the sof bit alone in position 0.
  logic [N-1:0]   sh_first;

  // Bit-insert helpers; the loop avoids indexing with the wider counter.
  always_comb begin
    sh_ins   = sh_q;
    sh_first = '0;
    sh_first[0] = sin;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        sh_ins[i] = sin;
      end
    end
  end

  // State, counter, shift register and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; idle cycles (sin_valid low) hold everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    d_d     = d_q;
    en_d    = 1'b0;
    err_d   = 1'b0;

    if (sin_valid) begin
      case (state_q)
        IDLE: begin
          // Stray data bits outside a frame are dropped without complaint.
          if (sof) begin
            sh_d    = sh_first;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end

        SHIFT: begin
          if (sof) begin
            // Abort-restart: the partial word is lost, the sof bit starts over.
            err_d   = 1'b1;
            sh_d    = sh_first;
            cnt_d   = CW'(1);
          end else if (cnt_q == LAST) begin
            sh_d = sh_ins;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            cnt_d   = CW'(N);
            state_d = PARITY;
`else
            d_d     = sh_ins;
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            sh_d  = sh_ins;
            cnt_d = cnt_q + CW'(1);
          end
        end

`ifdef SERIAL_WORD_LOADER_PARITY_EN
        PARITY: begin
          if (sof) begin
            err_d   = 1'b1;
            sh_d    = sh_first;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            // Even parity over data bits plus the parity bit.
            if ((^{sh_q, sin}) == 1'b0) begin
              d_d  = sh_q;
              en_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
`endif

        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign d         = d_q;
  assign en        = en_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - directed self-checking bench for serial_word_loader
module tb_serial_word_loader;

  localparam int N = 8;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         sof;
  logic [N-1:0] d;
  logic         en;
  logic         busy;
  logic         frame_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int t0;

  serial_word_loader #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sof       (sof),
    .d         (d),
    .en        (en),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, observe 1 ns later.
  task automatic step(input logic v, input logic b, input logic s);
    sin_valid = v;
    sin       = b;
    sof       = s;
    @(posedge clk);
    #1;
    cyc++;
    if (en) en_cnt++;
    if (frame_err) err_cnt++;
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic parity_bit(input logic [7:0] w);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    step(1'b1, ^w, 1'b0);
`else
    if (w === 8'hxx) step(1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int i = 0; i < N; i++) step(1'b1, w[i], i == 0);
    parity_bit(w);
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    #1;
    chk("rst_d", d, 8'h00);
    chk("rst_en", en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Single frame 0x0F.
    en_cnt = 0;
    step(1'b1, 1'b1, 1'b1);
    chk("t1_busy_rise", busy, 1'b1);
    for (int i = 1; i < N; i++) step(1'b1, (8'h0F >> i) & 1'b1, 1'b0);
    parity_bit(8'h0F);
    chk("t1_en", en, 1'b1);
    chk("t1_d", d, 8'h0F);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_err", frame_err, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_en_one_cycle", en, 1'b0);
    chk("t1_en_count", en_cnt, 1);

    // Back-to-back frames 0x0F then 0x33.
    en_cnt = 0;
    send_frame(8'h0F);
    chk("t2_en_a", en, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 4; i++) step(1'b1, (8'h33 >> i) & 1'b1, i == 0);
    chk("t2_d_hold", d, 8'h0F);
    for (int i = 4; i < N; i++) step(1'b1, (8'h33 >> i) & 1'b1, 1'b0);
    parity_bit(8'h33);
    chk("t2_en_b", en, 1'b1);
    chk("t2_d", d, 8'h33);
    chk("t2_spacing", cyc - t0, FL);
    chk("t2_en_count", en_cnt, 2);

    // Frame 0xF0 with gaps after bits 2 and 5.
    en_cnt = 0;
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      step(1'b1, (8'hF0 >> i) & 1'b1, i == 0);
      if (i == 2 || i == 5) begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b1);
        chk("t3_busy_gap", busy, 1'b1);
      end
    end
    parity_bit(8'hF0);
    chk("t3_en", en, 1'b1);
    chk("t3_d", d, 8'hF0);
    chk("t3_latency", cyc - t0, FL + 6);
    chk("t3_en_count", en_cnt, 1);

    // Abort-restart: 4 bits of 0xAA, then sof + 0x55.
    en_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, (8'hAA >> i) & 1'b1, i == 0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_err", frame_err, 1'b1);
    chk("t4_en_low", en, 1'b0);
    chk("t4_d_hold", d, 8'hF0);
    chk("t4_busy", busy, 1'b1);
    for (int i = 1; i < N; i++) step(1'b1, (8'h55 >> i) & 1'b1, 1'b0);
    parity_bit(8'h55);
    chk("t4_en", en, 1'b1);
    chk("t4_d", d, 8'h55);
    chk("t4_err_low", frame_err, 1'b0);
    chk("t4_en_count", en_cnt, 1);
    chk("t4_err_count", err_cnt, 1);

    // Asynchronous reset mid-frame.
    en_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_d_async", d, 8'h00);
    chk("t5_busy_async", busy, 1'b0);
    #2 reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_no_en", en_cnt, 0);
    chk("t5_no_err", err_cnt, 0);
    chk("t5_busy_idle_drop", busy, 1'b0);
    send_frame(8'h3C);
    chk("t5_en", en, 1'b1);
    chk("t5_d", d, 8'h3C);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    // Parity: good and bad parity on 0x07.
    for (int i = 0; i < N; i++) step(1'b1, (8'h07 >> i) & 1'b1, i == 0);
    step(1'b1, 1'b1, 1'b0);
    chk("p_en", en, 1'b1);
    chk("p_d", d, 8'h07);
    send_frame(8'h3C);
    for (int i = 0; i < N; i++) step(1'b1, (8'h07 >> i) & 1'b1, i == 0);
    step(1'b1, 1'b0, 1'b0);
    chk("p_err", frame_err, 1'b1);
    chk("p_no_en", en, 1'b0);
    chk("p_d_hold", d, 8'h3C);
    chk("p_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
